// File: rtl/neuron_core_arbiter.sv
// Two-master Wishbone arbiter in front of neuron_core.
// Round-robin on ties, no preemption, watchdog abort on stalled strobes.
module neuron_core_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_dat_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_dat_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  output logic [1:0]  grant_o,
  output logic [7:0]  err_cnt_o
);

  typedef enum logic [1:0] {
    IDLE,
    BUS0,
    BUS1,
    ERR
  } state_t;

  localparam logic [7:0] LP_TMO = 8'(TIMEOUT_CYCLES - 1);

  state_t     r_state;
  state_t     w_next;
  logic       r_last;
  logic       w_last_nxt;
  logic [7:0] r_wd;
  logic [7:0] w_wd_nxt;
  logic [7:0] r_err_cnt;
  logic       w_bus;
  logic       w_own_cyc;
  logic       w_own_stb;
  logic       w_stall;
  logic       w_tmo;

  assign w_bus     = (r_state == BUS0) || (r_state == BUS1);
  assign w_own_cyc = (r_state == BUS1) ? m1_cyc_i : m0_cyc_i;
  assign w_own_stb = (r_state == BUS1) ? m1_stb_i : m0_stb_i;
  assign w_stall   = w_bus && w_own_stb && !s_ack_i;
  // The last stalled cycle fires the abort; an ack in that cycle wins.
  assign w_tmo     = w_stall && (r_wd == LP_TMO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_last    <= 1'b1;
      r_wd      <= 8'd0;
      r_err_cnt <= 8'd0;
    end else begin
      r_state <= w_next;
      r_last  <= w_last_nxt;
      r_wd    <= w_wd_nxt;
      if (w_next == ERR && r_state != ERR && r_err_cnt != 8'hFF)
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_last_nxt = r_last;
    w_wd_nxt   = 8'd0;
    unique case (r_state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i)
          w_next = r_last ? BUS0 : BUS1;
        else if (m0_cyc_i)
          w_next = BUS0;
        else if (m1_cyc_i)
          w_next = BUS1;
      end
      BUS0, BUS1: begin
        if (!w_own_cyc) begin
          w_next     = IDLE;
          w_last_nxt = (r_state == BUS1);
        end else if (w_tmo) begin
          w_next     = ERR;
          w_last_nxt = (r_state == BUS1);
        end else if (w_stall) begin
          w_wd_nxt = r_wd + 8'd1;
        end
      end
      ERR: begin
        w_next = IDLE;
      end
    endcase
  end

  always_comb begin
    m0_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m0_dat_o  = 32'd0;
    m1_ack_o  = 1'b0;
    m1_err_o  = 1'b0;
    m1_dat_o  = 32'd0;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_sel_o   = 4'd0;
    s_adr_o   = 32'd0;
    s_dat_o   = 32'd0;
    grant_o   = 2'b00;
    unique case (r_state)
      IDLE: ;
      BUS0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i;
        m0_dat_o = s_dat_i;
        grant_o  = 2'b01;
      end
      BUS1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i;
        m1_dat_o = s_dat_i;
        grant_o  = 2'b10;
      end
      ERR: begin
        if (r_last) begin
          m1_err_o = 1'b1;
          m1_dat_o = ERR_DATA;
        end else begin
          m0_err_o = 1'b1;
          m0_dat_o = ERR_DATA;
        end
      end
    endcase
  end

  assign err_cnt_o = r_err_cnt;

endmodule

// File: tb/tb_neuron_core_arbiter.sv
// Directed bench for neuron_core_arbiter with TIMEOUT_CYCLES=4.
// Expected values are hand-derived per step.
module tb_neuron_core_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0;
  logic [3:0]  m0_sel_i = 0;
  logic [31:0] m0_adr_i = 0, m0_dat_i = 0;
  logic        m0_ack_o, m0_err_o;
  logic [31:0] m0_dat_o;
  logic        m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
  logic [3:0]  m1_sel_i = 0;
  logic [31:0] m1_adr_i = 0, m1_dat_i = 0;
  logic        m1_ack_o, m1_err_o;
  logic [31:0] m1_dat_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic        s_ack_i = 0;
  logic [31:0] s_dat_i = 0;
  logic [1:0]  grant_o;
  logic [7:0]  err_cnt_o;

  int n_pass = 0;
  int n_tot  = 0;

  neuron_core_arbiter #(
    .TIMEOUT_CYCLES(4),
    .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_sel_i(m0_sel_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_sel_i(m1_sel_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
    .grant_o(grant_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    // reset state
    #3;
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_scyc", 32'(s_cyc_o), 32'd0);
    chk("rst_errcnt", 32'(err_cnt_o), 32'd0);
    #4 rst_n = 1'b1;
    tick();

    // m0 single write, neuron_core acks on second cycle
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_sel_i = 4'hF;
    m0_adr_i = 32'h3000_0004; m0_dat_i = 32'h1234_5678;
    chk("w_idle_grant", 32'(grant_o), 32'd0);
    tick();
    chk("w_grant", 32'(grant_o), 32'd1);
    chk("w_adr", s_adr_o, 32'h3000_0004);
    chk("w_dat", s_dat_o, 32'h1234_5678);
    chk("w_noack", 32'(m0_ack_o), 32'd0);
    tick();
    s_ack_i = 1;
    #1;
    chk("w_ack", 32'(m0_ack_o), 32'd1);
    chk("w_m1ack", 32'(m1_ack_o), 32'd0);
    tick();
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
    #1;
    chk("w_ack_pulse", 32'(m0_ack_o), 32'd0);
    chk("w_hold_grant", 32'(grant_o), 32'd1);
    tick();
    chk("w_end_grant", 32'(grant_o), 32'd0);

    // tie round-robin from reset: m0, m1, m0
    rst_n = 0; #1; rst_n = 1;
    m0_cyc_i = 1; m1_cyc_i = 1;
    tick();
    chk("rr1_grant", 32'(grant_o), 32'd1);
    m0_cyc_i = 0;
    tick();
    chk("rr1_idle", 32'(grant_o), 32'd0);
    m0_cyc_i = 1;
    tick();
    chk("rr2_grant", 32'(grant_o), 32'd2);
    chk("rr2_m0dat", m0_dat_o, 32'd0);
    m1_cyc_i = 0;
    tick();
    chk("rr2_idle", 32'(grant_o), 32'd0);
    m1_cyc_i = 1;
    tick();
    chk("rr3_grant", 32'(grant_o), 32'd1);
    m0_cyc_i = 0; m1_cyc_i = 0;
    tick();
    chk("rr3_idle", 32'(grant_o), 32'd0);

    // m1 read never acked -> abort after 4 stalled cycles
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0; m1_adr_i = 32'h3000_0010;
    s_dat_i = 32'h5555_AAAA;
    tick();
    chk("to_grant", 32'(grant_o), 32'd2);
    tick(); tick(); tick();
    chk("to_c4_grant", 32'(grant_o), 32'd2);
    chk("to_c4_err", 32'(m1_err_o), 32'd0);
    tick();
    s_ack_i = 1;
    #1;
    chk("to_err", 32'(m1_err_o), 32'd1);
    chk("to_errdat", m1_dat_o, 32'hDEAD_BEEF);
    chk("to_noack", 32'(m1_ack_o), 32'd0);
    chk("to_scyc", 32'(s_cyc_o), 32'd0);
    chk("to_grant0", 32'(grant_o), 32'd0);
    chk("to_cnt", 32'(err_cnt_o), 32'd1);
    s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    tick();
    chk("to_err_pulse", 32'(m1_err_o), 32'd0);

    // ack on the 4th stalled cycle wins over the watchdog
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0;
    tick();
    tick(); tick(); tick();
    s_ack_i = 1;
    #1;
    chk("ak_ack", 32'(m0_ack_o), 32'd1);
    chk("ak_rdat", m0_dat_o, 32'h5555_AAAA);
    tick();
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    #1;
    chk("ak_noerr", 32'(m0_err_o), 32'd0);
    chk("ak_grant", 32'(grant_o), 32'd1);
    tick();
    chk("ak_cnt", 32'(err_cnt_o), 32'd1);

    // async reset mid-burst
    m0_cyc_i = 1; m0_stb_i = 1; s_ack_i = 1;
    tick();
    tick();
    chk("rb_burst_ack", 32'(m0_ack_o), 32'd1);
    rst_n = 0;
    #1;
    chk("rb_scyc", 32'(s_cyc_o), 32'd0);
    chk("rb_grant", 32'(grant_o), 32'd0);
    chk("rb_cnt", 32'(err_cnt_o), 32'd0);
    chk("rb_ack", 32'(m0_ack_o), 32'd0);
    rst_n = 1;
    tick();
    chk("rb_resume", 32'(grant_o), 32'd1);
    m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 0;
    tick();

    // repeated forced timeouts: 6 edges per abort
    rst_n = 0; #1; rst_n = 1;
    m1_cyc_i = 1; m1_stb_i = 1;
    repeat (600) tick();
    chk("sat_100", 32'(err_cnt_o), 32'd100);
    repeat (1200) tick();
    chk("sat_255", 32'(err_cnt_o), 32'd255);
    m1_cyc_i = 0; m1_stb_i = 0;
    repeat (3) tick();
    chk("sat_hold", 32'(err_cnt_o), 32'd255);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
